// File: rtl/registrador_sequencia_pkg.sv
// Shared types for the sequence register: decode of what an append request
// does in the current cycle, given the fill state and the wrap mode.
package registrador_sequencia_pkg;

    typedef enum logic [1:0] {
        OP_IDLE,    // no append this cycle
        OP_APPEND,  // room available: store and grow
        OP_DROP,    // full, no wrap: discard and flag overflow
        OP_WRAP     // full, wrap: overwrite oldest and flag overflow
    } append_op_e;

    function automatic append_op_e decode_append(input logic zera,
                                                 input logic enable,
                                                 input logic full,
                                                 input logic wrap);
        if (zera || !enable) return OP_IDLE;
        if (!full)           return OP_APPEND;
        return wrap ? OP_WRAP : OP_DROP;
    endfunction

endpackage

// File: rtl/registrador_sequencia_if.sv
// Append/read bus of the sequence register; the game FSM is the master.
interface registrador_sequencia_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) ();
    localparam int AW = $clog2(DEPTH);

    logic             zera;
    logic             enable;
    logic [WIDTH-1:0] D;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] last;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             overflow;

    modport master (
        output zera, enable, D, rd_en, rd_addr,
        input  Q, last, count, full, empty, overflow
    );

    modport slave (
        input  zera, enable, D, rd_en, rd_addr,
        output Q, last, count, full, empty, overflow
    );
endinterface

// File: rtl/registrador_n.sv
// WIDTH-bit register with load enable and asynchronous active-low clear.
module registrador_n #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)    Q <= '0;
        else if (enable) Q <= D;
    end
endmodule

// File: rtl/registrador_sequencia.sv
// Sequence recorder: appends words in arrival order and replays them by index
// from the oldest entry through a registered read port.
module registrador_sequencia
    import registrador_sequencia_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16,
    parameter bit WRAP  = 1'b0
) (
    input logic                   clock,
    input logic                   clear_n,
    registrador_sequencia_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    head;
    logic [AW-1:0]    rd_idx;
    logic [AW:0]      count_q;
    logic             overflow_q;
    logic             full;
    logic             store;
    logic             q_load;
    logic             last_load;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] last_next;
    append_op_e       op;

    assign full  = (count_q == CNT_FULL);
    assign op    = decode_append(bus.zera, bus.enable, full, WRAP);
    assign store = (op == OP_APPEND) || (op == OP_WRAP);

    // NOTE: the storage array is deliberately left without reset so it can map
    // onto LUT-RAM; stale words are never visible because reads are gated by count.
    always_ff @(posedge clock) begin
        if (store) mem[wr_ptr] <= bus.D;
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr     <= '0;
            head       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (bus.zera) begin
            wr_ptr     <= '0;
            head       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (op)
                OP_APPEND: begin
                    wr_ptr  <= wr_ptr + PTR_ONE;
                    count_q <= count_q + CNT_ONE;
                end
                OP_DROP: overflow_q <= 1'b1;
                OP_WRAP: begin
                    wr_ptr     <= wr_ptr + PTR_ONE;
                    head       <= head + PTR_ONE;
                    overflow_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Read sees pre-edge head/count/contents; out-of-range indices return zero.
    assign rd_idx  = head + bus.rd_addr;
    assign rd_data = ({1'b0, bus.rd_addr} < count_q) ? mem[rd_idx] : '0;

    assign q_load    = bus.rd_en | bus.zera;
    assign q_next    = bus.zera ? '0 : rd_data;
    assign last_load = store | bus.zera;
    assign last_next = bus.zera ? '0 : bus.D;

    registrador_n #(.WIDTH(WIDTH)) u_q (
        .clock   (clock),
        .clear_n (clear_n),
        .enable  (q_load),
        .D       (q_next),
        .Q       (bus.Q)
    );

    registrador_n #(.WIDTH(WIDTH)) u_last (
        .clock   (clock),
        .clear_n (clear_n),
        .enable  (last_load),
        .D       (last_next),
        .Q       (bus.last)
    );

    assign bus.count    = count_q;
    assign bus.full     = full;
    assign bus.empty    = (count_q == '0);
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_registrador_sequencia.sv
// Drives three sequence-register configurations (16/drop, 4/drop, 4/wrap) with
// one shared stimulus stream and checks them against a queue-based model.
module tb_registrador_sequencia;
    typedef logic [3:0] word_t;

    logic       clock;
    logic       clear_n;
    logic       zera;
    logic       enable;
    logic       rd_en;
    word_t      D;
    logic [3:0] rd_addr;

    int n_cmp = 0;
    int n_err = 0;

    registrador_sequencia_if #(.WIDTH(4), .DEPTH(16)) b16 ();
    registrador_sequencia_if #(.WIDTH(4), .DEPTH(4))  b4 ();
    registrador_sequencia_if #(.WIDTH(4), .DEPTH(4))  bw ();

    registrador_sequencia #(.WIDTH(4), .DEPTH(16), .WRAP(1'b0)) dut16 (
        .clock(clock), .clear_n(clear_n), .bus(b16));
    registrador_sequencia #(.WIDTH(4), .DEPTH(4), .WRAP(1'b0)) dut4 (
        .clock(clock), .clear_n(clear_n), .bus(b4));
    registrador_sequencia #(.WIDTH(4), .DEPTH(4), .WRAP(1'b1)) dutw (
        .clock(clock), .clear_n(clear_n), .bus(bw));

    assign b16.zera = zera;  assign b4.zera = zera;  assign bw.zera = zera;
    assign b16.enable = enable; assign b4.enable = enable; assign bw.enable = enable;
    assign b16.rd_en = rd_en; assign b4.rd_en = rd_en; assign bw.rd_en = rd_en;
    assign b16.D = D; assign b4.D = D; assign bw.D = D;
    assign b16.rd_addr = rd_addr;
    assign b4.rd_addr  = rd_addr[1:0];
    assign bw.rd_addr  = rd_addr[1:0];

    word_t      q_obs[3];
    word_t      last_obs[3];
    logic [4:0] cnt_obs[3];
    logic       full_obs[3];
    logic       empty_obs[3];
    logic       ovf_obs[3];

    assign q_obs[0] = b16.Q;    assign q_obs[1] = b4.Q;    assign q_obs[2] = bw.Q;
    assign last_obs[0] = b16.last; assign last_obs[1] = b4.last; assign last_obs[2] = bw.last;
    assign cnt_obs[0] = b16.count;
    assign cnt_obs[1] = {2'b00, b4.count};
    assign cnt_obs[2] = {2'b00, bw.count};
    assign full_obs[0] = b16.full;  assign full_obs[1] = b4.full;  assign full_obs[2] = bw.full;
    assign empty_obs[0] = b16.empty; assign empty_obs[1] = b4.empty; assign empty_obs[2] = bw.empty;
    assign ovf_obs[0] = b16.overflow; assign ovf_obs[1] = b4.overflow; assign ovf_obs[2] = bw.overflow;

    // Reference model: each configuration is an ordered queue, oldest at the front.
    int    dep[3] = '{16, 4, 4};
    bit    wrp[3] = '{1'b0, 1'b0, 1'b1};
    word_t mq[3][$];
    word_t exp_q[3][$];
    word_t m_last[3];
    logic  m_ovf[3];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            exp_q[i].delete();
            m_last[i] = '0;
            m_ovf[i]  = 1'b0;
        end
    endtask

    // One clock: apply inputs, advance the model and queue expected read data.
    task automatic cycle(input logic en, input word_t d, input logic rd,
                         input logic [3:0] addr, input logic z);
        zera = z; enable = en; D = d; rd_en = rd; rd_addr = addr;
        for (int i = 0; i < 3; i++) begin
            if (z) begin
                mq[i].delete();
                m_last[i] = '0;
                m_ovf[i]  = 1'b0;
            end else begin
                if (rd) begin
                    int a;
                    a = int'(addr) % dep[i];
                    exp_q[i].push_back(a < mq[i].size() ? mq[i][a] : 4'h0);
                end
                if (en) begin
                    if (mq[i].size() < dep[i]) begin
                        mq[i].push_back(d);
                        m_last[i] = d;
                    end else begin
                        m_ovf[i] = 1'b1;
                        if (wrp[i]) begin
                            void'(mq[i].pop_front());
                            mq[i].push_back(d);
                            m_last[i] = d;
                        end
                    end
                end
            end
        end
        @(posedge clock);
        #1;
        zera = 1'b0; enable = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (q_obs[i] !== 4'h0 || last_obs[i] !== 4'h0 || cnt_obs[i] !== 5'd0 ||
                ovf_obs[i] !== 1'b0 || empty_obs[i] !== 1'b1 || full_obs[i] !== 1'b0) begin
                n_err++;
                $display("FAIL reset[%0d]: got Q=%h last=%h count=%0d ovf=%b empty=%b full=%b, need 0/0/0/0/1/0",
                         i, q_obs[i], last_obs[i], cnt_obs[i], ovf_obs[i], empty_obs[i], full_obs[i]);
            end
        end
    endtask

    task automatic test_append_read();
        cycle(1'b1, 4'h1, 1'b0, 4'd0, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 4'd0, 1'b0);
        cycle(1'b1, 4'h3, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (cnt_obs[i] !== 5'd3 || last_obs[i] !== 4'h3 || empty_obs[i] !== 1'b0) begin
                n_err++;
                $display("FAIL append3[%0d]: got count=%0d last=%h empty=%b, need 3/3/0",
                         i, cnt_obs[i], last_obs[i], empty_obs[i]);
            end
        end
        for (int a = 0; a < 3; a++) begin
            cycle(1'b0, 4'h0, 1'b1, 4'(a), 1'b0);
            for (int i = 0; i < 3; i++) begin
                word_t e;
                e = exp_q[i].pop_front();
                n_cmp++;
                if (q_obs[i] !== e || e !== 4'(a + 1)) begin
                    n_err++;
                    $display("FAIL read_basic[%0d] addr %0d: got %h need %h", i, a, q_obs[i], 4'(a + 1));
                end
            end
        end
    endtask

    task automatic test_overflow();
        word_t spec_rd[3][4];
        spec_rd[0] = '{4'h1, 4'h2, 4'h3, 4'h4};
        spec_rd[1] = '{4'h1, 4'h2, 4'h3, 4'h4};
        spec_rd[2] = '{4'h3, 4'h4, 4'h5, 4'h6};
        cycle(1'b0, 4'h0, 1'b0, 4'd0, 1'b1);
        for (int k = 1; k <= 6; k++) cycle(1'b1, 4'(k), 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (cnt_obs[i] !== 5'(mq[i].size()) || full_obs[i] !== (mq[i].size() == dep[i]) ||
                ovf_obs[i] !== m_ovf[i] || last_obs[i] !== m_last[i]) begin
                n_err++;
                $display("FAIL overflow[%0d]: got count=%0d full=%b ovf=%b last=%h, need %0d/%b/%b/%h",
                         i, cnt_obs[i], full_obs[i], ovf_obs[i], last_obs[i],
                         mq[i].size(), mq[i].size() == dep[i], m_ovf[i], m_last[i]);
            end
        end
        for (int a = 0; a < 4; a++) begin
            cycle(1'b0, 4'h0, 1'b1, 4'(a), 1'b0);
            for (int i = 0; i < 3; i++) begin
                word_t e;
                e = exp_q[i].pop_front();
                n_cmp++;
                if (q_obs[i] !== spec_rd[i][a] || e !== spec_rd[i][a]) begin
                    n_err++;
                    $display("FAIL read_overflow[%0d] addr %0d: got %h need %h", i, a, q_obs[i], spec_rd[i][a]);
                end
            end
        end
    endtask

    task automatic test_zera();
        cycle(1'b1, 4'hF, 1'b1, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (cnt_obs[i] !== 5'd0 || q_obs[i] !== 4'h0 || last_obs[i] !== 4'h0 ||
                ovf_obs[i] !== 1'b0 || empty_obs[i] !== 1'b1) begin
                n_err++;
                $display("FAIL zera[%0d]: got count=%0d Q=%h last=%h ovf=%b empty=%b, need 0/0/0/0/1",
                         i, cnt_obs[i], q_obs[i], last_obs[i], ovf_obs[i], empty_obs[i]);
            end
        end
        cycle(1'b0, 4'h0, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            word_t e;
            e = exp_q[i].pop_front();
            n_cmp++;
            if (q_obs[i] !== e) begin
                n_err++;
                $display("FAIL zera_nostore[%0d]: got %h need %h", i, q_obs[i], e);
            end
        end
    endtask

    task automatic test_out_of_range();
        cycle(1'b1, 4'h1, 1'b0, 4'd0, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 4'd0, 1'b0);
        cycle(1'b0, 4'h0, 1'b1, 4'd3, 1'b0);
        cycle(1'b1, 4'hA, 1'b1, 4'd2, 1'b0);
        cycle(1'b0, 4'h0, 1'b1, 4'd2, 1'b0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) begin
                word_t e;
                e = exp_q[i].pop_front();
                n_cmp++;
                if (e !== ((r == 2) ? 4'hA : 4'h0)) begin
                    n_err++;
                    $display("FAIL range_model[%0d] step %0d: model %h", i, r, e);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (q_obs[i] !== 4'hA || cnt_obs[i] !== 5'd3) begin
                n_err++;
                $display("FAIL range_final[%0d]: got Q=%h count=%0d, need A/3", i, q_obs[i], cnt_obs[i]);
            end
        end
    endtask

    task automatic test_range_steps();
        // Per-cycle view of the same-cycle read/append case.
        cycle(1'b0, 4'h0, 1'b0, 4'd0, 1'b1);
        cycle(1'b1, 4'h1, 1'b0, 4'd0, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 4'd0, 1'b0);
        cycle(1'b0, 4'h0, 1'b1, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            void'(exp_q[i].pop_front());
            n_cmp++;
            if (q_obs[i] !== 4'h0) begin
                n_err++;
                $display("FAIL range_oob[%0d]: got %h need 0", i, q_obs[i]);
            end
        end
        cycle(1'b1, 4'hA, 1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            void'(exp_q[i].pop_front());
            n_cmp++;
            if (q_obs[i] !== 4'h0) begin
                n_err++;
                $display("FAIL range_prewrite[%0d]: got %h need 0", i, q_obs[i]);
            end
        end
        cycle(1'b0, 4'h0, 1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            void'(exp_q[i].pop_front());
            n_cmp++;
            if (q_obs[i] !== 4'hA) begin
                n_err++;
                $display("FAIL range_postwrite[%0d]: got %h need A", i, q_obs[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        word_t hold[3];
        cycle(1'b0, 4'h0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) hold[i] = '0;
        for (int n = 0; n < 80; n++) begin
            logic z, en, rd;
            z  = ($urandom_range(0, 39) == 0);
            en = ($urandom_range(0, 2) != 0);
            rd = ($urandom_range(0, 1) == 1);
            cycle(en, 4'($urandom), rd, 4'($urandom_range(0, 15)), z);
            for (int i = 0; i < 3; i++) begin
                if (z) hold[i] = '0;
                else if (rd) hold[i] = exp_q[i].pop_front();
                n_cmp++;
                if (q_obs[i] !== hold[i]) begin
                    n_err++;
                    $display("FAIL b2b_q[%0d] cycle %0d: got %h need %h", i, n, q_obs[i], hold[i]);
                end
                n_cmp++;
                if (cnt_obs[i] !== 5'(mq[i].size()) || last_obs[i] !== m_last[i] ||
                    ovf_obs[i] !== m_ovf[i] || full_obs[i] !== (mq[i].size() == dep[i]) ||
                    empty_obs[i] !== (mq[i].size() == 0)) begin
                    n_err++;
                    $display("FAIL b2b_state[%0d] cycle %0d: got count=%0d last=%h ovf=%b, need %0d/%h/%b",
                             i, n, cnt_obs[i], last_obs[i], ovf_obs[i], mq[i].size(), m_last[i], m_ovf[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 4'h0, 1'b0, 4'd0, 1'b1);
        cycle(1'b1, 4'h5, 1'b0, 4'd0, 1'b0);
        cycle(1'b1, 4'h6, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) void'(exp_q[i].pop_front());
        // Pending append and read are in flight when clear_n drops mid-cycle.
        enable = 1'b1; D = 4'h7; rd_en = 1'b1; rd_addr = 4'd1;
        #2 clear_n = 1'b0;
        #1;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (q_obs[i] !== 4'h0 || last_obs[i] !== 4'h0 || cnt_obs[i] !== 5'd0 ||
                ovf_obs[i] !== 1'b0 || empty_obs[i] !== 1'b1) begin
                n_err++;
                $display("FAIL async_reset[%0d]: got Q=%h last=%h count=%0d ovf=%b empty=%b",
                         i, q_obs[i], last_obs[i], cnt_obs[i], ovf_obs[i], empty_obs[i]);
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (q_obs[i] !== 4'h0 || cnt_obs[i] !== 5'd0) begin
                n_err++;
                $display("FAIL async_hold[%0d]: got Q=%h count=%0d, need 0/0", i, q_obs[i], cnt_obs[i]);
            end
        end
        enable = 1'b0; rd_en = 1'b0;
        #2 clear_n = 1'b1;
        cycle(1'b1, 4'h9, 1'b0, 4'd0, 1'b0);
        cycle(1'b0, 4'h0, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            word_t e;
            e = exp_q[i].pop_front();
            n_cmp++;
            if (q_obs[i] !== 4'h9 || e !== 4'h9 || cnt_obs[i] !== 5'd1) begin
                n_err++;
                $display("FAIL after_reset[%0d]: got Q=%h count=%0d, need 9/1", i, q_obs[i], cnt_obs[i]);
            end
        end
    endtask

    initial begin
        clear_n = 1'b0;
        zera = 1'b0; enable = 1'b0; rd_en = 1'b0; D = '0; rd_addr = '0;
        model_clear();
        #12;
        test_reset();
        clear_n = 1'b1;
        test_append_read();
        test_overflow();
        test_zera();
        test_out_of_range();
        test_range_steps();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
